config_chain_receiver: RTL



---
 rtl/config_pkg.sv | 13 +
 rtl/config_chain_receiver_if.sv | 32 +++
 rtl/config_lane_rx.sv | 59 +++++
 rtl/config_chain_receiver.sv | 49 ++++
 4 files changed

// File: rtl/config_pkg.sv
// Constants shared between the Wishbone configurator and the fabric-side
// configuration chain receiver, plus the lane-slice index helper for cfg_o.
package config_pkg;

  localparam int CFG_NUM_LANES = 4;
  localparam int CFG_CHAIN_LEN = 8;
  localparam int CFG_CNT_W     = 8;

  function automatic int lane_lsb(input int lane, input int chain_len);
    return lane * chain_len;
  endfunction

endpackage

// File: rtl/config_chain_receiver_if.sv
// Configuration stream bundle: configurator-driven cen/set/shift plus the
// receiver's chain-through, committed config and bring-up status.
interface config_chain_receiver_if
  import config_pkg::*;
#(
  parameter int LANES     = CFG_NUM_LANES,
  parameter int CHAIN_LEN = CFG_CHAIN_LEN,
  parameter int CNT_W     = CFG_CNT_W
);

  // No backpressure: every edge with cen=1 consumes shift_in and set_in
  // unconditionally; with cen=0 both are ignored and all state holds.
  logic                       cen;
  logic [LANES-1:0]           set_in;
  logic [LANES-1:0]           shift_in;
  logic [LANES-1:0]           shift_out;
  logic [LANES*CHAIN_LEN-1:0] cfg_o;
  logic [LANES-1:0]           cfg_updated;
  logic [LANES*CNT_W-1:0]     bit_count;
  logic [LANES-1:0]           len_err;

  modport master (
    output cen, set_in, shift_in,
    input  shift_out, cfg_o, cfg_updated, bit_count, len_err
  );

  modport slave (
    input  cen, set_in, shift_in,
    output shift_out, cfg_o, cfg_updated, bit_count, len_err
  );

endinterface

// File: rtl/config_lane_rx.sv
// One configuration lane: LSB-first deserializer into a shadow register,
// commit into the held config word, chain-through bit, shift counter, flag.
module config_lane_rx
  import config_pkg::*;
#(
  parameter int CHAIN_LEN = CFG_CHAIN_LEN,
  parameter int CNT_W     = CFG_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  config_chain_receiver_if.slave  lane
);

  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] cfg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 shift_out_q;
  logic                 upd_q;
  logic                 err_q;

  // New bit enters at the MSB so the first bit received ends up in bit 0.
  always_comb begin
    shadow_d                = shadow_q >> 1;
    shadow_d[CHAIN_LEN-1]   = lane.shift_in[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      cfg_q       <= '0;
      cnt_q       <= '0;
      shift_out_q <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (lane.cen) begin
        shadow_q    <= shadow_d;
        shift_out_q <= shadow_q[0];
        if (lane.set_in[0]) begin
          // Commit the pre-edge shadow; the same-cycle shift counts as bit 1.
          cfg_q <= shadow_q;
          cnt_q <= CNT_W'(1);
          err_q <= err_q | (cnt_q != CNT_W'(CHAIN_LEN));
          upd_q <= 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign lane.shift_out[0]   = shift_out_q;
  assign lane.cfg_o          = cfg_q;
  assign lane.cfg_updated[0] = upd_q;
  assign lane.bit_count      = cnt_q;
  assign lane.len_err[0]     = err_q;

endmodule

// File: rtl/config_chain_receiver.sv
// Fabric-side end of the configuration stream: NUM_LANES independent
// receive lanes whose outputs are concatenated onto the flat output buses.
module config_chain_receiver
  import config_pkg::*;
#(
  parameter int NUM_LANES = CFG_NUM_LANES,
  parameter int CHAIN_LEN = CFG_CHAIN_LEN,
  parameter int CNT_W     = CFG_CNT_W
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           cen,
  input  logic [NUM_LANES-1:0]           set_in,
  input  logic [NUM_LANES-1:0]           shift_in,
  output logic [NUM_LANES-1:0]           shift_out,
  output logic [NUM_LANES*CHAIN_LEN-1:0] cfg_o,
  output logic [NUM_LANES-1:0]           cfg_updated,
  output logic [NUM_LANES*CNT_W-1:0]     bit_count,
  output logic [NUM_LANES-1:0]           len_err
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    config_chain_receiver_if #(
      .LANES     (1),
      .CHAIN_LEN (CHAIN_LEN),
      .CNT_W     (CNT_W)
    ) lane_bus ();

    assign lane_bus.cen         = cen;
    assign lane_bus.set_in[0]   = set_in[g];
    assign lane_bus.shift_in[0] = shift_in[g];

    config_lane_rx #(
      .CHAIN_LEN (CHAIN_LEN),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .lane (lane_bus.slave)
    );

    assign shift_out[g]                                   = lane_bus.shift_out[0];
    assign cfg_o[lane_lsb(g, CHAIN_LEN) +: CHAIN_LEN]     = lane_bus.cfg_o;
    assign cfg_updated[g]                                 = lane_bus.cfg_updated[0];
    assign bit_count[lane_lsb(g, CNT_W) +: CNT_W]         = lane_bus.bit_count;
    assign len_err[g]                                     = lane_bus.len_err[0];
  end

endmodule
